lfsr_run_ctrl: RTL and testbench

- Sequencer for one external Fibonacci LFSR instance with taps MSB^LSB, shift-left, and a combinational "state == seed" done flag.
- On a start request it seeds the LFSR, then steps it a programmed number of times. It holds the seed stable so the LFSR done compare stays valid.
- It measures the sequence period, reports the final LFSR value, and rejects the all-zero lock-up seed.
- Sits between a host/test sequencer and the LFSR datapath.

---
 rtl/lfsr_run_ctrl.sv | 108 ++++++++++
 tb/tb_lfsr_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_run_ctrl.sv
// Seeds an external Fibonacci LFSR, steps it a programmed number of times, and measures its period.
// Define LFSR_RUN_CTRL_STOP_ON_PERIOD_EN to end the run in the cycle where the period is detected.
module lfsr_run_ctrl #(
  parameter int NUM_BITS  = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic [NUM_BITS-1:0]  i_Seed,
  input  logic [CNT_WIDTH-1:0] i_Steps,
  output logic                 o_LFSR_Enable,
  output logic                 o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0]  o_LFSR_Seed_Data,
  input  logic [NUM_BITS-1:0]  i_LFSR_Data,
  input  logic                 i_LFSR_Done,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_Error,
  output logic                 o_Found,
  output logic [CNT_WIDTH-1:0] o_Period,
  output logic [NUM_BITS-1:0]  o_Final_Data
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} t_State;

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  t_State               r_State;
  logic [NUM_BITS-1:0]  r_Seed;
  logic [CNT_WIDTH-1:0] r_N;
  logic [CNT_WIDTH-1:0] r_Taken;

  logic w_AtEnd;
  logic w_Match;
  logic w_Stop;

  // The LFSR also flags "state == seed" right after loading; that trivial hit is skipped via r_Taken != 0.
  assign w_AtEnd = (r_Taken == r_N);
  assign w_Match = (r_State == RUN) && (r_Taken != '0) && i_LFSR_Done && !o_Found;

`ifdef LFSR_RUN_CTRL_STOP_ON_PERIOD_EN
  assign w_Stop = w_AtEnd || w_Match;
`else
  assign w_Stop = w_AtEnd;
`endif

  // Enable depends on the live LFSR done flag, so it is decoded rather than registered.
  assign o_LFSR_Enable    = (r_State == LOAD) || ((r_State == RUN) && !w_Stop);
  assign o_LFSR_Seed_DV   = (r_State == LOAD);
  assign o_LFSR_Seed_Data = r_Seed;
  assign o_Busy           = (r_State != IDLE);
  assign o_Done           = (r_State == DONE);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State      <= IDLE;
      r_Seed       <= '0;
      r_N          <= '0;
      r_Taken      <= '0;
      o_Error      <= 1'b0;
      o_Found      <= 1'b0;
      o_Period     <= '0;
      o_Final_Data <= '0;
    end else begin
      case (r_State)
        IDLE: begin
          if (i_Start) begin
            r_Seed   <= i_Seed;
            r_N      <= i_Steps;
            r_Taken  <= '0;
            o_Found  <= 1'b0;
            o_Period <= '0;
            if (i_Seed == '0) begin
              o_Error <= 1'b1;
              r_State <= DONE;
            end else begin
              o_Error <= 1'b0;
              r_State <= LOAD;
            end
          end
        end
        LOAD: begin
          r_State <= RUN;
        end
        RUN: begin
          if (w_Match) begin
            o_Found  <= 1'b1;
            o_Period <= r_Taken;
          end
          if (w_Stop) begin
            o_Final_Data <= i_LFSR_Data;
            r_State      <= DONE;
          end else begin
            r_Taken <= r_Taken + ONE;
          end
        end
        DONE: begin
          r_State <= IDLE;
        end
        default: begin
          r_State <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Testbench for lfsr_run_ctrl: a bench-side LFSR plus a scoreboard fed by a sequence-table reference model.
// Honours LFSR_RUN_CTRL_STOP_ON_PERIOD_EN the same way the design does.
module tb_lfsr_run_ctrl;

  localparam int NB = 3;
  localparam int CW = 8;

  typedef struct {
    int            doneCycle;
    logic          err;
    logic          found;
    logic [CW-1:0] period;
    logic [NB-1:0] fin;
    logic [NB-1:0] seed;
    int            enCount;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_Rst = 1'b1;
  logic          i_Start = 1'b0;
  logic [NB-1:0] i_Seed = '0;
  logic [CW-1:0] i_Steps = '0;
  logic          o_LFSR_Enable;
  logic          o_LFSR_Seed_DV;
  logic [NB-1:0] o_LFSR_Seed_Data;
  logic [NB-1:0] lfsrReg = '0;
  logic          lfsrDone;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Error;
  logic          o_Found;
  logic [CW-1:0] o_Period;
  logic [NB-1:0] o_Final_Data;

  int   cycleCnt = 0;
  int   checkCount = 0;
  int   errCount = 0;
  int   enSeen = 0;
  exp_t sbQ[$];
  logic [NB-1:0] succ [8];
  logic [NB-1:0] modelFinal = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  lfsr_run_ctrl #(.NUM_BITS(NB), .CNT_WIDTH(CW)) dut (
    .i_Clk(clk),
    .i_Rst(i_Rst),
    .i_Start(i_Start),
    .i_Seed(i_Seed),
    .i_Steps(i_Steps),
    .o_LFSR_Enable(o_LFSR_Enable),
    .o_LFSR_Seed_DV(o_LFSR_Seed_DV),
    .o_LFSR_Seed_Data(o_LFSR_Seed_Data),
    .i_LFSR_Data(lfsrReg),
    .i_LFSR_Done(lfsrDone),
    .o_Busy(o_Busy),
    .o_Done(o_Done),
    .o_Error(o_Error),
    .o_Found(o_Found),
    .o_Period(o_Period),
    .o_Final_Data(o_Final_Data)
  );

  // External LFSR: taps MSB^LSB, shift left, never reset by i_Rst
  always @(posedge clk) begin
    if (o_LFSR_Enable)
      lfsrReg <= o_LFSR_Seed_DV ? o_LFSR_Seed_Data
                                : {lfsrReg[NB-2:0], lfsrReg[NB-1] ^ lfsrReg[0]};
  end
  assign lfsrDone = (lfsrReg == o_LFSR_Seed_Data);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Reference model: walk the published successor table, stop at N steps (or at the period if enabled)
  function automatic exp_t computeExpect(input logic [NB-1:0] seed, input logic [CW-1:0] steps, input int startCycle);
    exp_t e;
    logic [NB-1:0] v;
    int taken;
    bit stopped;
    e.seed = seed;
    e.found = 1'b0;
    e.period = '0;
    if (seed == '0) begin
      e.err = 1'b1;
      e.fin = modelFinal;
      e.doneCycle = startCycle + 1;
      e.enCount = 0;
    end else begin
      e.err = 1'b0;
      v = seed;
      taken = 0;
      stopped = 1'b0;
      for (int k = 1; k <= int'(steps) && !stopped; k++) begin
        v = succ[v];
        taken = k;
        if (!e.found && v == seed) begin
          e.found = 1'b1;
          e.period = CW'(k);
`ifdef LFSR_RUN_CTRL_STOP_ON_PERIOD_EN
          stopped = 1'b1;
`endif
        end
      end
      e.fin = v;
      e.doneCycle = startCycle + taken + 3;
      e.enCount = taken + 1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [NB-1:0] seed, input logic [CW-1:0] steps, input bit expectDone);
    exp_t e;
    @(posedge clk); #1;
    i_Start = 1'b1;
    i_Seed = seed;
    i_Steps = steps;
    if (expectDone) begin
      e = computeExpect(seed, steps, cycleCnt);
      modelFinal = e.fin;
      sbQ.push_back(e);
    end
    @(posedge clk); #1;
    i_Start = 1'b0;
    i_Seed = NB'($urandom);
    i_Steps = CW'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((sbQ.size() != 0 || o_Busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) checkOutput("waitIdleTimeout", 32'(sbQ.size()), 0);
  endtask

  task automatic checkResetState();
    checkOutput("rstBusy", 32'(o_Busy), 0);
    checkOutput("rstDone", 32'(o_Done), 0);
    checkOutput("rstEnable", 32'(o_LFSR_Enable), 0);
    checkOutput("rstSeedDv", 32'(o_LFSR_Seed_DV), 0);
    checkOutput("rstSeedData", 32'(o_LFSR_Seed_Data), 0);
    checkOutput("rstError", 32'(o_Error), 0);
    checkOutput("rstFound", 32'(o_Found), 0);
    checkOutput("rstPeriod", 32'(o_Period), 0);
    checkOutput("rstFinal", 32'(o_Final_Data), 0);
  endtask

  // Monitor: counts enable cycles and scores each completion pulse against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (i_Rst) begin
      enSeen = 0;
    end else begin
      if (o_LFSR_Enable) enSeen++;
      if (o_Done) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'(o_Done), 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("doneCycle", 32'(cycleCnt), 32'(e.doneCycle));
          checkOutput("busyAtDone", 32'(o_Busy), 1);
          checkOutput("error", 32'(o_Error), 32'(e.err));
          checkOutput("found", 32'(o_Found), 32'(e.found));
          checkOutput("period", 32'(o_Period), 32'(e.period));
          checkOutput("finalData", 32'(o_Final_Data), 32'(e.fin));
          checkOutput("seedHeld", 32'(o_LFSR_Seed_Data), 32'(e.seed));
          checkOutput("enableCycles", 32'(enSeen), 32'(e.enCount));
        end
        enSeen = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NB-1:0] seqList [7];
    seqList = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
    succ[0] = '0;
    for (int i = 0; i < 7; i++) succ[seqList[i]] = seqList[(i + 1) % 7];

    repeat (3) @(posedge clk);
    #1;
    i_Rst = 1'b0;
    checkResetState();

    $display("[TB] directed runs");
    applyStimulus(3'b001, 8'd5, 1'b1);
    waitIdle(600);
    applyStimulus(3'b001, 8'd10, 1'b1);
    waitIdle(600);
    applyStimulus(3'b000, 8'd4, 1'b1);
    waitIdle(600);

    // Steps=0 with a second start issued while the first run is in RUN
    applyStimulus(3'b110, 8'd0, 1'b1);
    i_Start = 1'b1;
    i_Seed = 3'b011;
    i_Steps = 8'd5;
    @(posedge clk); #1;
    i_Start = 1'b0;
    waitIdle(600);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("ignoredStartBusy", 32'(o_Busy), 0);

    // Reset three steps into a run
    applyStimulus(3'b011, 8'd20, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    i_Rst = 1'b1;
    @(posedge clk); #1;
    i_Rst = 1'b0;
    modelFinal = '0;
    checkResetState();
    applyStimulus(3'b001, 8'd7, 1'b1);
    waitIdle(600);

    // Longest programmable run
    applyStimulus(3'b111, 8'd255, 1'b1);
    waitIdle(600);

    $display("[TB] random runs");
    for (int r = 0; r < 25; r++) begin
      applyStimulus(NB'($urandom_range(0, 7)), CW'($urandom_range(0, 20)), 1'b1);
      waitIdle(600);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
